// File: rtl/rpn_sequencer.sv
// rpn_sequencer: buffers RPN instructions in a FIFO and issues them to a stack calculator while tracking its depth.
// Define RPN_SEQ_ERRCHK_EN to enable underflow/overflow detection with HALT and clr recovery.
module rpn_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        step,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [17:0] in_instr,
    output logic        in_ready,
    output logic        push,
    output logic [15:0] d,
    output logic [1:0]  op,
    input  logic        clr,
    output logic [9:0]  depth,
    output logic        err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, HALT = 2'd2;
    logic [17:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [1:0]  state, state_n, kind;
    logic [17:0] head;
    logic [9:0]  depth_n;
    logic        full, empty, wr_en, rd_en, bad, go, err_n;

    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign wr_en    = in_valid && !full;
    assign rd_en    = (state == ISSUE) && !empty;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign kind     = head[17:16];
    assign wr_ptr_n = wr_ptr + (AW+1)'(wr_en);
    assign rd_ptr_n = rd_ptr + (AW+1)'(rd_en);

`ifdef RPN_SEQ_ERRCHK_EN
    assign bad   = rd_en && ((kind == 2'b00) ? (depth == 10'd1023) :
                             (kind == 2'b01) ? (depth == 10'd0) : (depth < 10'd2));
    assign err_n = bad || (err && !(state == HALT && clr));
`else
    assign bad   = 1'b0;
    assign err_n = 1'b0;
`endif

    assign go = rd_en && !bad;
    // Saturation only matters unchecked; with checking the erroring cases never reach here.
    assign depth_n = !go ? depth :
                     (kind == 2'b00) ? ((depth == 10'd1023) ? depth : depth + 10'd1) :
                     (kind == 2'b01) ? depth :
                     ((depth == 10'd0) ? depth : depth - 10'd1);
    assign state_n = (bad || (state == HALT && !clr)) ? HALT :
                     (wr_ptr_n == rd_ptr_n) ? IDLE : ISSUE;

    always_ff @(posedge step or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
            push   <= 1'b0;
            d      <= 16'd0;
            op     <= 2'b00;
            depth  <= 10'd0;
            err    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            state  <= state_n;
            push   <= go && (kind == 2'b00);
            d      <= (go && (kind == 2'b00)) ? head[15:0] : 16'd0;
            op     <= go ? kind : 2'b00;
            depth  <= depth_n;
            err    <= err_n;
        end
    end

    always_ff @(posedge step) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= in_instr;
    end
endmodule
